// File: rtl/disp_ctrl.sv
// disp_ctrl: memory-mapped value register driving a 4-digit multiplexed 7-segment display.
// Build option DISP_DEC_EN selects signed-decimal display via double-dabble; default shows hex.
module disp_ctrl #(
  parameter int DATA_W      = 16,
  parameter int REFRESH_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel,
  input  logic              we,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic [7:0]        Disp,
  output logic [3:0]        Disp_sel
);
  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  logic              wr_en;
  logic [DATA_W-1:0] value_q, value_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        idx_q, idx_d;
  logic [7:0]        disp_q, disp_d;
  logic [3:0]        disp_sel_q, disp_sel_d;
  logic [3:0]        nib;

  function automatic logic [7:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 8'hC0;
      4'h1: glyph = 8'hF9;
      4'h2: glyph = 8'hA4;
      4'h3: glyph = 8'hB0;
      4'h4: glyph = 8'h99;
      4'h5: glyph = 8'h92;
      4'h6: glyph = 8'h82;
      4'h7: glyph = 8'hF8;
      4'h8: glyph = 8'h80;
      4'h9: glyph = 8'h90;
      4'hA: glyph = 8'h88;
      4'hB: glyph = 8'h83;
      4'hC: glyph = 8'hC6;
      4'hD: glyph = 8'hA1;
      4'hE: glyph = 8'h86;
      default: glyph = 8'h8E;
    endcase
  endfunction

  assign wr_en    = sel && we;
  assign data_out = value_q;
  assign Disp     = disp_q;
  assign Disp_sel = disp_sel_q;

  // The digit index only advances when the refresh counter wraps, so each digit stays lit REFRESH_DIV cycles.
  always_comb begin
    value_d    = wr_en ? data_in : value_q;
    cnt_d      = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
    idx_d      = (cnt_q == CNT_MAX) ? idx_q + 2'd1 : idx_q;
    disp_sel_d = ~(4'b0001 << idx_q);
  end

`ifdef DISP_DEC_EN
  localparam int BIT_W = $clog2(DATA_W);
  localparam logic [BIT_W-1:0] BIT_MAX = BIT_W'(DATA_W - 1);

  typedef enum logic {IDLE, CONV} state_t;

  state_t            state_q, state_d;
  logic [19:0]       bcd_q, bcd_d, bcd_adj, bcd_shift;
  logic [DATA_W-1:0] bin_q, bin_d, mag;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic              neg_q, neg_d;
  logic              busy_q, busy_d;
  logic              disp_neg_q, disp_neg_d;
  logic [19:0]       disp_bcd_q, disp_bcd_d;

  // A new write always restarts the conversion; the shown result only changes when a conversion completes.
  always_comb begin
    for (int k = 0; k < 5; k++) begin
      bcd_adj[4*k +: 4] = (bcd_q[4*k +: 4] >= 4'd5) ? bcd_q[4*k +: 4] + 4'd3 : bcd_q[4*k +: 4];
    end
    bcd_shift  = {bcd_adj[18:0], bin_q[DATA_W-1]};
    mag        = data_in[DATA_W-1] ? (~data_in + 1'b1) : data_in;
    state_d    = state_q;
    bcd_d      = bcd_q;
    bin_d      = bin_q;
    bit_d      = bit_q;
    neg_d      = neg_q;
    disp_neg_d = disp_neg_q;
    disp_bcd_d = disp_bcd_q;
    if (wr_en) begin
      state_d = CONV;
      bcd_d   = '0;
      bin_d   = mag;
      bit_d   = '0;
      neg_d   = data_in[DATA_W-1];
    end else if (state_q == CONV) begin
      bcd_d = bcd_shift;
      bin_d = bin_q << 1;
      bit_d = bit_q + 1'b1;
      if (bit_q == BIT_MAX) begin
        state_d    = IDLE;
        disp_neg_d = neg_q;
        disp_bcd_d = bcd_shift;
      end
    end
    busy_d = (state_d == CONV);
  end

  always_comb begin
    case (idx_q)
      2'd0:    nib = disp_bcd_q[3:0];
      2'd1:    nib = disp_bcd_q[7:4];
      default: nib = disp_bcd_q[11:8];
    endcase
    if (idx_q == 2'd3)            disp_d = disp_neg_q ? 8'hBF : 8'hFF;
    else if (|disp_bcd_q[19:12])  disp_d = 8'h86;
    else                          disp_d = glyph(nib);
  end

  assign busy = busy_q;
`else
  always_comb begin
    case (idx_q)
      2'd0:    nib = value_q[3:0];
      2'd1:    nib = value_q[7:4];
      2'd2:    nib = value_q[11:8];
      default: nib = value_q[15:12];
    endcase
    disp_d = glyph(nib);
  end

  assign busy = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q    <= '0;
      cnt_q      <= '0;
      idx_q      <= 2'd0;
      disp_q     <= 8'hC0;
      disp_sel_q <= 4'b1110;
`ifdef DISP_DEC_EN
      state_q    <= IDLE;
      bcd_q      <= '0;
      bin_q      <= '0;
      bit_q      <= '0;
      neg_q      <= 1'b0;
      busy_q     <= 1'b0;
      disp_neg_q <= 1'b0;
      disp_bcd_q <= '0;
`endif
    end else begin
      value_q    <= value_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      disp_q     <= disp_d;
      disp_sel_q <= disp_sel_d;
`ifdef DISP_DEC_EN
      state_q    <= state_d;
      bcd_q      <= bcd_d;
      bin_q      <= bin_d;
      bit_q      <= bit_d;
      neg_q      <= neg_d;
      busy_q     <= busy_d;
      disp_neg_q <= disp_neg_d;
      disp_bcd_q <= disp_bcd_d;
`endif
    end
  end
endmodule

// File: tb/tb_disp_ctrl.sv
// tb_disp_ctrl: directed bench for disp_ctrl with an arithmetic display model checked every cycle.
// Build with DISP_DEC_EN defined to exercise the decimal display.
module tb_disp_ctrl;
  logic        clk;
  logic        rst;
  logic        sel;
  logic        we;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        busy;
  logic [7:0]  Disp;
  logic [3:0]  Disp_sel;

  int total = 0;
  int bad   = 0;
  bit chkEn = 0;

  localparam logic [7:0] HEX_TAB [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                          8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  disp_ctrl #(.DATA_W(16), .REFRESH_DIV(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .sel      (sel),
    .we       (we),
    .data_in  (data_in),
    .data_out (data_out),
    .busy     (busy),
    .Disp     (Disp),
    .Disp_sel (Disp_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: edges since reset release, written value, shown source and pending conversion.
  int          mEdges;
  int          mConvLeft;
  logic [15:0] mValue;
  logic [15:0] mSrc;
  logic [15:0] mPending;
  logic [7:0]  expDisp;
  logic [3:0]  expSel;
  logic        expBusy;

  function automatic logic [7:0] digitGlyph(input int idx, input logic [15:0] src);
`ifdef DISP_DEC_EN
    int v;
    int mag;
    int scale;
    v     = int'($signed(src));
    mag   = (v < 0) ? -v : v;
    scale = (idx == 0) ? 1 : (idx == 1) ? 10 : 100;
    if (idx == 3) return (v < 0) ? 8'hBF : 8'hFF;
    if (mag > 999) return 8'h86;
    return HEX_TAB[(mag / scale) % 10];
`else
    return HEX_TAB[(src >> (4 * idx)) & 16'hF];
`endif
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mEdges    = 0;
      mConvLeft = 0;
      mValue    = 16'h0;
      mSrc      = 16'h0;
      mPending  = 16'h0;
      expDisp   = 8'hC0;
      expSel    = 4'b1110;
      expBusy   = 1'b0;
    end else begin
      expSel  = ~(4'b0001 << ((mEdges / 4) % 4));
      expDisp = digitGlyph((mEdges / 4) % 4, mSrc);
      mEdges++;
      if (sel && we) mValue = data_in;
`ifdef DISP_DEC_EN
      if (sel && we) begin
        mPending  = data_in;
        mConvLeft = 16;
      end else if (mConvLeft > 0) begin
        mConvLeft--;
        if (mConvLeft == 0) mSrc = mPending;
      end
      expBusy = (mConvLeft > 0);
`else
      mSrc    = mValue;
      expBusy = 1'b0;
`endif
    end
  end

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chkEn) begin
      checkOutput("model_disp", {8'h0, Disp}, {8'h0, expDisp});
      checkOutput("model_sel", {12'h0, Disp_sel}, {12'h0, expSel});
      checkOutput("model_busy", {15'h0, busy}, {15'h0, expBusy});
      checkOutput("model_dout", data_out, mValue);
    end
  end

  task automatic waitEdges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic w, input logic [15:0] d, input int cycles);
    sel     = s;
    we      = w;
    data_in = d;
    waitEdges(cycles);
    sel = 1'b0;
    we  = 1'b0;
  endtask

  task automatic checkDisp(input string name, input logic [7:0] d, input logic [3:0] s);
    checkOutput({name, "_disp"}, {8'h0, Disp}, {8'h0, d});
    checkOutput({name, "_sel"}, {12'h0, Disp_sel}, {12'h0, s});
  endtask

  task automatic resetDut();
    rst = 1'b1;
    waitEdges(2);
    rst = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    sel     = 1'b0;
    we      = 1'b0;
    data_in = 16'h0;
    waitEdges(3);
    checkDisp("reset", 8'hC0, 4'b1110);
    checkOutput("reset_busy", {15'h0, busy}, 16'h0);
    checkOutput("reset_dout", data_out, 16'h0);
    chkEn = 1'b1;

    rst = 1'b0;
    applyStimulus(1'b1, 1'b1, 16'h12AB, 1);
    checkOutput("write_dout", data_out, 16'h12AB);
`ifndef DISP_DEC_EN
    waitEdges(1);
    checkDisp("hex_d0", 8'h83, 4'b1110);
    waitEdges(2);
    checkDisp("hex_d0_last", 8'h83, 4'b1110);
    waitEdges(1);
    checkDisp("hex_d1", 8'h88, 4'b1101);
    waitEdges(4);
    checkDisp("hex_d2", 8'hA4, 4'b1011);
    waitEdges(4);
    checkDisp("hex_d3", 8'hF9, 4'b0111);
    waitEdges(4);
    checkDisp("hex_wrap", 8'h83, 4'b1110);
`endif

    applyStimulus(1'b1, 1'b0, 16'hFFFF, 1);
    checkOutput("ignore_we0", data_out, 16'h12AB);
    applyStimulus(1'b0, 1'b1, 16'hFFFF, 1);
    checkOutput("ignore_sel0", data_out, 16'h12AB);

    // Reset in the middle of the digit-2 slot, asserted between clock edges.
    for (int i = 0; i < 64; i++) begin
      if (Disp_sel == 4'b1011) break;
      waitEdges(1);
    end
    checkOutput("scan_at_idx2", {12'h0, Disp_sel}, 16'h000B);
    #2;
    rst = 1'b1;
    #1;
    checkDisp("async_rst", 8'hC0, 4'b1110);
    waitEdges(1);
    checkDisp("rst_hold", 8'hC0, 4'b1110);
    rst = 1'b0;
    waitEdges(4);
    checkDisp("restart_d0", 8'hC0, 4'b1110);
    waitEdges(1);
    checkDisp("restart_d1", 8'hC0, 4'b1101);

`ifdef DISP_DEC_EN
    resetDut();
    applyStimulus(1'b1, 1'b1, 16'hFFFC, 1);
    checkOutput("neg_busy_first", {15'h0, busy}, 16'h1);
    checkOutput("neg_dout_raw", data_out, 16'hFFFC);
    waitEdges(15);
    checkOutput("neg_busy_last", {15'h0, busy}, 16'h1);
    waitEdges(1);
    checkOutput("neg_busy_done", {15'h0, busy}, 16'h0);
    checkDisp("neg_old_held", 8'hC0, 4'b1110);
    waitEdges(1);
    checkDisp("neg_d0", 8'h99, 4'b1110);
    waitEdges(3);
    checkDisp("neg_d1", 8'hC0, 4'b1101);
    waitEdges(4);
    checkDisp("neg_d2", 8'hC0, 4'b1011);
    waitEdges(4);
    checkDisp("neg_sign", 8'hBF, 4'b0111);

    resetDut();
    applyStimulus(1'b1, 1'b1, 16'd3, 1);
    waitEdges(17);
    checkDisp("pos_d0", 8'hB0, 4'b1110);
    waitEdges(3);
    checkDisp("pos_d1", 8'hC0, 4'b1101);
    waitEdges(8);
    checkDisp("pos_sign", 8'hFF, 4'b0111);

    resetDut();
    applyStimulus(1'b1, 1'b1, 16'd1000, 1);
    waitEdges(17);
    checkDisp("ovf_d0", 8'h86, 4'b1110);
    waitEdges(7);
    checkDisp("ovf_d2", 8'h86, 4'b1011);
    waitEdges(4);
    checkDisp("ovf_sign", 8'hFF, 4'b0111);

    resetDut();
    applyStimulus(1'b1, 1'b1, 16'd3, 1);
    waitEdges(16);
    applyStimulus(1'b1, 1'b1, 16'd5, 1);
    waitEdges(6);
    applyStimulus(1'b1, 1'b1, 16'd9, 1);
    waitEdges(8);
    checkDisp("restart_held", 8'hB0, 4'b1110);
    checkOutput("restart_busy", {15'h0, busy}, 16'h1);
    waitEdges(8);
    checkOutput("restart_done", {15'h0, busy}, 16'h0);
    waitEdges(8);
    checkDisp("restart_d0", 8'h90, 4'b1110);
`endif

    waitEdges(2);
    chkEn = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
